// File: rtl/gift_pkg.sv
// rtl/gift_pkg.sv - GIFT-128 key-schedule constants, FSM encoding and word rotations
package gift_pkg;

  localparam int GIFT128_ROUNDS = 40;
  localparam int ROT_UPD_HI = 2;
  localparam int ROT_UPD_LO = 12;
  localparam int ROT_INV_HI = 16 - ROT_UPD_HI;
  localparam int ROT_INV_LO = 16 - ROT_UPD_LO;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WIND = 2'd1,
    ST_EMIT = 2'd2
  } ks_state_t;

  function automatic logic [15:0] ror16(input logic [15:0] x, input int unsigned n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [31:0] upd(input logic [31:0] x);
    return {ror16(x[31:16], ROT_UPD_HI), ror16(x[15:0], ROT_UPD_LO)};
  endfunction

  function automatic logic [31:0] inv(input logic [31:0] x);
    return {ror16(x[31:16], ROT_INV_HI), ror16(x[15:0], ROT_INV_LO)};
  endfunction

endpackage

// File: rtl/gift_ks_step.sv
// rtl/gift_ks_step.sv - one forward (dir=0) or backward (dir=1) GIFT-128 key-state step
module gift_ks_step
  import gift_pkg::*;
(
  input  logic [127:0] state,
  input  logic         dir,
  output logic [127:0] state_next
);

  logic [31:0] k3, k2, k1, k0;

  assign {k3, k2, k1, k0} = state;
  assign state_next = dir ? {k2, k1, k0, inv(k3)} : {upd(k0), k3, k2, k1};

endmodule

// File: rtl/gift_ks_seq.sv
// rtl/gift_ks_seq.sv - iterative GIFT-128 round-key sequencer, encrypt or reversed decrypt order
module gift_ks_seq
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT128_ROUNDS,
  parameter int IDXW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_dec,
  input  logic [127:0]    in_key,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [31:0]     rk_u,
  output logic [31:0]     rk_v,
  output logic [IDXW-1:0] rk_idx,
  output logic            rk_last
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROUNDS - 1);
  localparam logic [IDXW-1:0] WIND_END = IDXW'(ROUNDS - 2);

  ks_state_t       fsm, fsm_nxt;
  logic [127:0]    key, key_nxt;
  logic            dec;
  logic [IDXW-1:0] idx;

  // WIND always steps forward; only an accepted decrypt key steps backward
  gift_ks_step u_step (
    .state      (key),
    .dir        (dec && (fsm == ST_EMIT)),
    .state_next (key_nxt)
  );

  assign in_ready = (fsm == ST_IDLE);
  assign rk_valid = (fsm == ST_EMIT);
  assign rk_last  = rk_valid && (dec ? (idx == '0) : (idx == LAST_IDX));
  assign rk_u     = key[95:64];
  assign rk_v     = key[31:0];
  assign rk_idx   = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= ST_IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_IDLE: if (in_valid) fsm_nxt = (in_dec && (ROUNDS > 1)) ? ST_WIND : ST_EMIT;
      ST_WIND: if (idx == WIND_END) fsm_nxt = ST_EMIT;
      ST_EMIT: if (rk_ready && rk_last) fsm_nxt = ST_IDLE;
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // idx doubles as the wind counter, so it lands on ROUNDS-1 exactly when WIND ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key <= '0;
      dec <= 1'b0;
      idx <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            key <= in_key;
            dec <= in_dec;
            idx <= '0;
          end
        end
        ST_WIND: begin
          key <= key_nxt;
          idx <= idx + IDXW'(1);
        end
        ST_EMIT: begin
          if (rk_ready && !rk_last) begin
            key <= key_nxt;
            idx <= dec ? (idx - IDXW'(1)) : (idx + IDXW'(1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_ks_seq.sv
// tb/tb_gift_ks_seq.sv - self-checking bench for gift_ks_seq (ROUNDS=40 and ROUNDS=1 instances)
module tb_gift_ks_seq;

  localparam int R = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, in_dec = 1'b0;
  logic [127:0] in_key = '0;
  logic         rk_valid, rk_ready = 1'b1, rk_last;
  logic [31:0]  rk_u, rk_v;
  logic [5:0]   rk_idx;

  logic         s_in_valid = 1'b0, s_in_ready, s_in_dec = 1'b0;
  logic [127:0] s_in_key = '0;
  logic         s_rk_valid, s_rk_ready = 1'b1, s_rk_last;
  logic [31:0]  s_rk_u, s_rk_v;
  logic [0:0]   s_rk_idx;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] seq_u [0:63];
  logic [31:0] seq_v [0:63];
  logic [31:0] enc_u [0:63];
  logic [31:0] enc_v [0:63];

  always #5 clk = ~clk;

  gift_ks_seq #(.ROUNDS(R), .IDXW(6)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_key(in_key),
    .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_u(rk_u), .rk_v(rk_v), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  gift_ks_seq #(.ROUNDS(1), .IDXW(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_dec(s_in_dec), .in_key(s_in_key),
    .rk_valid(s_rk_valid), .rk_ready(s_rk_ready),
    .rk_u(s_rk_u), .rk_v(s_rk_v), .rk_idx(s_rk_idx), .rk_last(s_rk_last)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rotate right by n expressed as a bit-index permutation
  function automatic logic [15:0] m_ror(input logic [15:0] x, input int n);
    logic [15:0] y;
    for (int i = 0; i < 16; i++) y[i] = x[(i + n) % 16];
    return y;
  endfunction

  function automatic logic [31:0] m_upd(input logic [31:0] x);
    return {m_ror(x[31:16], 2), m_ror(x[15:0], 12)};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    check({tag, "_rk_u"},     128'(rk_u),     128'(0));
    check({tag, "_rk_v"},     128'(rk_v),     128'(0));
    check({tag, "_rk_idx"},   128'(rk_idx),   128'(0));
    check({tag, "_rk_last"},  128'(rk_last),  128'(0));
  endtask

  task automatic request(input logic dec, input logic [127:0] key);
    int g;
    g = 0;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("req_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_dec   = dec;
    in_key   = key;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Schedule as a word recurrence: W[i+4] = upd(W[i]), round r has U=W[r+2], V=W[r]
  task automatic run_stream(input logic dec, input logic [127:0] key, input bit bp, input bit noise);
    logic [31:0] w [0:R+2];
    int r, n, lat, g;
    bit acc;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < R + 3; i++) w[i] = m_upd(w[i-4]);
    rk_ready = 1'b1;
    request(dec, key);
    lat = 1;
    while (rk_valid !== 1'b1 && lat < R + 20) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_dec   = ~dec;
        in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    check("latency", 128'(lat), 128'(dec ? R : 1));
    n = 0;
    g = 0;
    while (n < R && g < 2000) begin
      r = dec ? (R - 1 - n) : n;
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("rk_idx",   128'(rk_idx),   128'(r));
      check("rk_u",     128'(rk_u),     128'(w[r+2]));
      check("rk_v",     128'(rk_v),     128'(w[r]));
      check("rk_last",  128'(rk_last),  128'(n == R - 1));
      check("in_ready_busy", 128'(in_ready), 128'(0));
      if (dec && n == R - 1) begin
        check("dec_final_u", 128'(rk_u), 128'(key[95:64]));
        check("dec_final_v", 128'(rk_v), 128'(key[31:0]));
      end
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = rk_ready;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_dec   = ~dec;
        in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      if (acc) begin
        seq_u[n] = rk_u;
        seq_v[n] = rk_v;
      end
      @(negedge clk);
      g++;
      if (acc) n++;
    end
    in_valid = 1'b0;
    rk_ready = 1'b1;
    check("stream_done", 128'(n), 128'(R));
    check("bubble_in_ready", 128'(in_ready), 128'(1));
    check("bubble_rk_valid", 128'(rk_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] k;
    int g;

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run_stream(1'b0, {96'h0, 32'h0000_0001}, 1'b0, 1'b0);
    check("k1_rk0_u", 128'(seq_u[0]), 128'(0));
    check("k1_rk0_v", 128'(seq_v[0]), 128'(32'h0000_0001));
    for (int i = 1; i < 4; i++) check("k1_rk123_v", 128'(seq_v[i]), 128'(0));
    check("k1_rk4_v", 128'(seq_v[4]), 128'(32'h0000_0010));

    run_stream(1'b0, {96'h0, 32'h0001_0000}, 1'b0, 1'b0);
    check("k10000_rk4_v", 128'(seq_v[4]), 128'(32'h4000_0000));

    run_stream(1'b0, {96'h0, 32'hFFFF_FFFF}, 1'b0, 1'b0);
    for (int i = 0; i < R; i++)
      check("ones_v", 128'(seq_v[i]), 128'((i % 4 == 0) ? 32'hFFFF_FFFF : 32'h0));

    for (int t = 0; t < 2; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_stream(1'b0, k, 1'b0, 1'b0);
      for (int i = 0; i < R; i++) begin
        enc_u[i] = seq_u[i];
        enc_v[i] = seq_v[i];
      end
      run_stream(1'b1, k, 1'b0, 1'b0);
      for (int i = 0; i < R; i++) begin
        check("rev_u", 128'(seq_u[i]), 128'(enc_u[R-1-i]));
        check("rev_v", 128'(seq_v[i]), 128'(enc_v[R-1-i]));
      end
    end

    for (int t = 0; t < 4; t++)
      run_stream(1'(t % 2), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);

    k = {$urandom, $urandom, $urandom, $urandom};
    request(1'b1, k);
    repeat (9) @(negedge clk);
    check("mid_wind_busy", 128'(rk_valid), 128'(0));
    #2 rst = 1'b1;
    #1 check_reset("rst_wind");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_resume_wind", 128'(rk_valid), 128'(0));
    end
    run_stream(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    request(1'b0, k);
    g = 0;
    while (!(rk_valid === 1'b1 && rk_idx == 6'd20) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("mid_emit_idx", 128'(rk_idx), 128'(20));
    #2 rst = 1'b1;
    #1 check_reset("rst_emit");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_resume_emit", 128'(rk_valid), 128'(0));
    end
    run_stream(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      check("r1_in_ready", 128'(s_in_ready), 128'(1));
      s_in_valid = 1'b1;
      s_in_dec   = 1'(d);
      s_in_key   = k;
      @(negedge clk);
      s_in_valid = 1'b0;
      check("r1_rk_valid", 128'(s_rk_valid), 128'(1));
      check("r1_rk_idx",   128'(s_rk_idx),   128'(0));
      check("r1_rk_last",  128'(s_rk_last),  128'(1));
      check("r1_rk_u",     128'(s_rk_u),     128'(k[95:64]));
      check("r1_rk_v",     128'(s_rk_v),     128'(k[31:0]));
      @(negedge clk);
      check("r1_done_valid", 128'(s_rk_valid), 128'(0));
      check("r1_done_ready", 128'(s_in_ready), 128'(1));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gift_ks_seq.md
Name: gift_ks_seq

Overview:
- Iterative GIFT-128 round-key sequencer. Accepts a 128-bit master key and streams the 32-bit round-key pairs (U,V) one round at a time.
- Two directions:
  - Encrypt: forward key update, rounds emitted 0 → ROUNDS-1.
  - Decrypt: winds forward, then steps backwards with the inverse key update, so rounds are emitted ROUNDS-1 → 0.
- Sits beside the GIFT ISE datapath. Feeds round keys to the cipher core or a memory writer without storing the whole schedule.

Parameters:
- ROUNDS, 40: number of round keys emitted per request; legal range 1..64.
- IDXW, 6: width of rk_idx; must satisfy 2**IDXW >= ROUNDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  key request valid.
- in_ready  out  1  block can accept a request.
- in_dec  in  1  direction; sampled on the request handshake (1 = decrypt order).
- in_key  in  128  master key; K[127:96]=k3, K[95:64]=k2, K[63:32]=k1, K[31:0]=k0.
- rk_valid  out  1  round key valid.
- rk_ready  in  1  consumer accepts the round key.
- rk_u  out  32  U = k2 of the current state.
- rk_v  out  32  V = k0 of the current state.
- rk_idx  out  IDXW  round number of the presented key.
- rk_last  out  1  marks the final key of the request.

Behaviour:
- Word functions:
  - upd(x) = {ror16(x[31:16],2), ror16(x[15:0],12)}.
  - inv(x) = {ror16(x[31:16],14), ror16(x[15:0],4)}.
  - inv(upd(x)) = x for all x.
- State step operations:
  - Forward: (k3,k2,k1,k0) ← (upd(k0), k3, k2, k1).
  - Backward: (k3,k2,k1,k0) ← (k2, k1, k0, inv(k3)).
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch key, in_dec and counter.
    - Encrypt: go to EMIT with idx=0.
    - Decrypt with ROUNDS>1: go to WIND with cnt=0.
    - Decrypt with ROUNDS=1: go to EMIT with idx=0.
  - WIND: one forward step per cycle; in_ready=0, rk_valid=0. After ROUNDS-1 steps go to EMIT with idx=ROUNDS-1.
  - EMIT: rk_valid=1; rk_u, rk_v, rk_idx, rk_last are driven from registers. On rk_valid&&rk_ready:
    - Not last: step the state (encrypt forward with idx+1; decrypt backward with idx-1).
    - Last: go to IDLE.
    - rk_last=1 when idx==ROUNDS-1 (encrypt) or idx==0 (decrypt).
- Backpressure: while rk_ready=0, rk_u, rk_v, rk_idx and rk_last stay stable and the state does not step.
- Busy: in_valid outside IDLE is ignored; in_key and in_dec are not sampled.
- Latency from request handshake to first rk_valid:
  - Encrypt: 1 cycle.
  - Decrypt: ROUNDS cycles.
- Throughput: one key per cycle under continuous rk_ready.
- Back-to-back requests: in_ready rises the cycle after the last handshake, giving one idle bubble between requests.
- Reset: takes effect immediately in any state, including mid-WIND or mid-EMIT. State → IDLE; in_ready=1; rk_valid=0; rk_u=0, rk_v=0, rk_idx=0, rk_last=0; key registers cleared; no partial stream resumes after reset.
- Wrap-around: the counter never wraps because transitions are bounded by ROUNDS.
- Arithmetic: rotations are bit permutations only; no carries.

Decomposition:
- Package gift_pkg holds:
  - Constants GIFT128_ROUNDS=40 and the rotation amounts (2, 12 and their complements 14, 4).
  - FSM state encoding (IDLE, WIND, EMIT).
  - Word functions upd/inv.
- One natural sub-module: gift_ks_step. Purely combinational; inputs 128-bit state and dir; output the next state via forward or backward step.
- The FSM, counter and handshake logic stay in gift_ks_seq.

Test Plan:
- Encrypt, key k3..k0=0,0,0,0x00000001, rk_ready=1:
  - rk0 (U,V)=(0,0x00000001); rk1..rk3 V=0.
  - rk4 V=0x00000010; rk_last only on idx 39.
- Encrypt, k0=0x00010000 → rk4 V=0x40000000; k0=0xFFFFFFFF → every rk V equals 0xFFFFFFFF every 4th round.
- Decrypt, random key:
  - First rk_valid exactly 40 cycles after the handshake.
  - The sequence idx 39..0 equals the encrypt sequence reversed, bit-exact.
  - rk_last on idx 0; the final state equals the master key.
- Backpressure: toggle rk_ready pseudo-randomly → outputs are stable while stalled, there are no skipped or duplicated idx values, and in_valid pulses during busy are ignored.
- Reset asserted mid-WIND (cycle 10) and mid-EMIT (idx 20):
  - Outputs return immediately to their reset values.
  - After release, a new encrypt request produces rk0 correctly.
- ROUNDS=1 instance, decrypt and encrypt: a single key with idx 0, rk_last=1, 1-cycle latency, no WIND.
